// File: rtl/alu_bcd_pkg.sv
// Shared constants and types for the ALU's BCD conversion blocks.
// The BCD_BLANK_EN build option that uses BCD_BLANK is handled in bcd_to_bin_converter.
package alu_bcd_pkg;

    localparam logic [3:0] BCD_BLANK     = 4'hF;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd2bin_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse-double-dabble digit correction: a digit of 8 or more loses 3.
// Pure combinational logic, so the caller decides when the result is registered.
module bcd_digit_adjust
    import alu_bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    assign digit_out = (digit_in >= 4'd8) ? digit_in - 4'd3 : digit_in;

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Multi-cycle packed-BCD to binary converter (reverse double dabble, one result bit per cycle).
// Define BCD_BLANK_EN to accept 4'hF in the top digit as a blanked zero.
module bcd_to_bin_converter
    import alu_bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    bcd2bin_state_t      state, state_next;
    logic [WORK_W-1:0]   work, work_next;
    logic [CNT_W-1:0]    count, count_next;
    logic [BIN_W-1:0]    bin_next;
    logic                err_next;
    logic [BCD_W-1:0]    digits_norm;
    logic                operand_ok;
    logic                blank_top;
    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    adjusted;

    assign shifted = work >> 1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (shifted[BIN_W + 4*g +: 4]),
                .digit_out (adjusted[4*g +: 4])
            );
        end
    endgenerate

`ifdef BCD_BLANK_EN
    assign blank_top = (bcd[BCD_W-1 -: 4] == BCD_BLANK);
`else
    assign blank_top = 1'b0;
`endif

    // A blanked top digit becomes 0; any other nibble above 9 rejects the operand.
    always_comb begin
        digits_norm = bcd;
        operand_ok  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i == DIGITS - 1) && blank_top) begin
                digits_norm[4*i +: 4] = 4'd0;
            end else if (bcd[4*i +: 4] > BCD_MAX_DIGIT) begin
                operand_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        work_next  = work;
        count_next = count;
        bin_next   = bin;
        err_next   = err;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (operand_ok) begin
                        work_next  = {digits_norm, {BIN_W{1'b0}}};
                        count_next = CNT_W'(BIN_W);
                        state_next = SHIFT;
                    end else begin
                        bin_next   = '0;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                work_next  = {adjusted, shifted[BIN_W-1:0]};
                count_next = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    bin_next   = shifted[BIN_W-1:0];
                    err_next   = 1'b0;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            count <= '0;
            bin   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            work  <= work_next;
            count <= count_next;
            bin   <= bin_next;
            err   <= err_next;
            busy  <= (state_next == SHIFT);
            done  <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Directed self-checking bench for bcd_to_bin_converter (2 digits, 7-bit result).
// Expectations follow BCD_BLANK_EN when the bench is built with it defined.
module tb_bcd_to_bin_converter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] bcd;
    logic       busy;
    logic       done;
    logic [6:0] bin;
    logic       err;

    int vector_count = 0;
    int miss_count   = 0;
    int lat;
    int busy_cycles;
    int done_seen;

    bcd_to_bin_converter #(.DIGITS(2), .BIN_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        assert (observed === expected) else begin
            miss_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Called at a negedge: start is sampled on the next rising edge (edge N); returns in cycle N+1.
    task automatic applyStimulus(input logic [7:0] value);
        bcd   = value;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcd   = ~value;
    endtask

    // Latency 1 means done is high in the cycle this task was entered in.
    task automatic waitDone(output int latency, output int busy_count);
        latency    = 1;
        busy_count = 0;
        while (!done && latency < 20) begin
            if (busy) busy_count++;
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic countDone(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bcd   = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_bin",  bin,  0);
        checkOutput("reset_err",  err,  0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'h42);
        waitDone(lat, busy_cycles);
        checkOutput("lat_42",  lat, 8);
        checkOutput("busy_42", busy_cycles, 7);
        checkOutput("bin_42",  bin, 42);
        checkOutput("err_42",  err, 0);
        @(negedge clk);
        checkOutput("pulse_42", done, 0);
        checkOutput("idle_42",  busy, 0);
        checkOutput("hold_42",  bin, 42);

        applyStimulus(8'h99);
        waitDone(lat, busy_cycles);
        checkOutput("lat_99", lat, 8);
        checkOutput("bin_99", bin, 99);
        applyStimulus(8'h00);
        waitDone(lat, busy_cycles);
        checkOutput("lat_00_b2b", lat, 8);
        checkOutput("bin_00",     bin, 0);
        checkOutput("err_00",     err, 0);
        @(negedge clk);

        applyStimulus(8'hF7);
        waitDone(lat, busy_cycles);
`ifdef BCD_BLANK_EN
        checkOutput("lat_F7", lat, 8);
        checkOutput("bin_F7", bin, 7);
        checkOutput("err_F7", err, 0);
`else
        checkOutput("lat_F7",  lat, 1);
        checkOutput("bin_F7",  bin, 0);
        checkOutput("err_F7",  err, 1);
        checkOutput("busy_F7", busy_cycles, 0);
`endif
        @(negedge clk);

        applyStimulus(8'h3A);
        waitDone(lat, busy_cycles);
        checkOutput("lat_3A",  lat, 1);
        checkOutput("bin_3A",  bin, 0);
        checkOutput("err_3A",  err, 1);
        checkOutput("busy_3A", busy, 0);
        @(negedge clk);

        applyStimulus(8'hF3);
        waitDone(lat, busy_cycles);
`ifdef BCD_BLANK_EN
        checkOutput("bin_F3", bin, 3);
        checkOutput("err_F3", err, 0);
`else
        checkOutput("bin_F3", bin, 0);
        checkOutput("err_F3", err, 1);
`endif
        @(negedge clk);

        applyStimulus(8'h5F);
        waitDone(lat, busy_cycles);
        checkOutput("lat_5F", lat, 1);
        checkOutput("err_5F", err, 1);
        checkOutput("bin_5F", bin, 0);
        repeat (2) @(negedge clk);

        // Second start lands on edge N+3 while busy and must be dropped.
        applyStimulus(8'h25);
        repeat (2) @(negedge clk);
        bcd   = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("err_held_mid", err, 1);
        waitDone(lat, busy_cycles);
        checkOutput("lat_25_ignore", lat, 5);
        checkOutput("bin_25",        bin, 25);
        checkOutput("err_25",        err, 0);
        countDone(12, done_seen);
        checkOutput("no_second_done", done_seen, 0);

        applyStimulus(8'h55);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_done", done, 0);
        checkOutput("rst_mid_bin",  bin,  0);
        checkOutput("rst_mid_err",  err,  0);
        @(negedge clk);
        rst_n = 1'b1;
        countDone(12, done_seen);
        checkOutput("rst_no_done", done_seen, 0);
        checkOutput("rst_idle",    busy, 0);

        applyStimulus(8'h07);
        waitDone(lat, busy_cycles);
        checkOutput("lat_07", lat, 8);
        checkOutput("bin_07", bin, 7);
        checkOutput("err_07", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
